// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave responder.
package i2c_pkg;

  // Byte-level protocol phases of the slave.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Line level of the acknowledge bit; NACK is also the released (Z) level.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // R/W bit carried in bit 0 of the address byte.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iSCL,
  input  logic iSDA,
  output logic oSDA,
  output logic oSCL_RISE,
  output logic oSCL_FALL,
  output logic oSTART,
  output logic oSTOP
);

  logic [SYNC_STAGES-1:0] sclPipe;
  logic [SYNC_STAGES-1:0] sdaPipe;
  logic                   sclPrev;
  logic                   sdaPrev;
  logic                   sclNow;
  logic                   sdaNow;
  logic                   sdaRise;
  logic                   sdaFall;

  // Synchronizer chains plus one history flop; idle bus level is high.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sclPipe <= '1;
      sdaPipe <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclPipe <= {sclPipe[SYNC_STAGES-2:0], iSCL};
      sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], iSDA};
      sclPrev <= sclPipe[SYNC_STAGES-1];
      sdaPrev <= sdaPipe[SYNC_STAGES-1];
    end
  end

  // Single-cycle events; START/STOP need SCL high in both samples so a
  // simultaneous SCL/SDA change is treated as an ordinary data bit.
  always_comb begin
    sclNow    = sclPipe[SYNC_STAGES-1];
    sdaNow    = sdaPipe[SYNC_STAGES-1];
    oSDA      = sdaNow;
    oSCL_RISE = sclNow & ~sclPrev;
    oSCL_FALL = ~sclNow & sclPrev;
    sdaRise   = sdaNow & ~sdaPrev;
    sdaFall   = ~sdaNow & sdaPrev;
    oSTART    = sdaFall & sclNow & sclPrev;
    oSTOP     = sdaRise & sclNow & sclPrev;
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave decoding [SLAVE_ADDR, SUB_ADDR, DATA] frames into register
// write strobes and serving byte reads from a register-read port.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oWR_EN,
  output logic [7:0] oRD_ADDR,
  output logic       oRD_REQ,
  input  logic [7:0] iRD_DATA,
  output logic       oBUSY
);

  i2c_state_e state;
  logic [3:0] bitCnt;
  logic [6:0] shiftReg;
  logic [7:0] txShift;
  logic [7:0] pointer;
  logic       sdaOut;
  logic       ackPhase;
  logic       rwBit;

  logic       sdaNow;
  logic       sclRise;
  logic       sclFall;
  logic       busStart;
  logic       busStop;
  logic [7:0] rxByte;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uLineSync (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iSCL      (I2C_SCLK),
    .iSDA      (I2C_SDAT),
    .oSDA      (sdaNow),
    .oSCL_RISE (sclRise),
    .oSCL_FALL (sclFall),
    .oSTART    (busStart),
    .oSTOP     (busStop)
  );

  // Open-drain: only ever pull low or release.
  assign I2C_SDAT = (sdaOut == 1'b0) ? 1'b0 : 1'bz;

  // Byte being completed on the current SCL rise.
  always_comb begin
    rxByte = {shiftReg, sdaNow};
  end

  // Protocol FSM, shifters, register pointer and registered outputs.
  // ACK states use ackPhase: phase 0 waits for the SCL fall after the 8th
  // bit (start driving ACK), phase 1 waits for the fall ending the ACK bit.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      txShift  <= '0;
      pointer  <= '0;
      sdaOut   <= I2C_NACK;
      ackPhase <= 1'b0;
      rwBit    <= RW_WRITE;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
      oWR_EN   <= 1'b0;
      oRD_ADDR <= '0;
      oRD_REQ  <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      oWR_EN  <= 1'b0;
      oRD_REQ <= 1'b0;
      if (busStop) begin
        state    <= ST_IDLE;
        oBUSY    <= 1'b0;
        sdaOut   <= I2C_NACK;
        bitCnt   <= '0;
        ackPhase <= 1'b0;
      end else if (busStart) begin
        state    <= ST_ADDR;
        oBUSY    <= 1'b1;
        sdaOut   <= I2C_NACK;
        bitCnt   <= '0;
        ackPhase <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (sclRise) begin
              shiftReg <= rxByte[6:0];
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd7) begin
                bitCnt <= '0;
                if (rxByte[7:1] == SLAVE_ADDR) begin
                  rwBit    <= rxByte[0];
                  ackPhase <= 1'b0;
                  state    <= ST_ADDR_ACK;
                  if (rxByte[0] == RW_READ) begin
                    oRD_REQ  <= 1'b1;
                    oRD_ADDR <= pointer;
                  end
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (sclFall) begin
              if (!ackPhase) begin
                sdaOut   <= I2C_ACK;
                ackPhase <= 1'b1;
              end else begin
                ackPhase <= 1'b0;
                bitCnt   <= '0;
                if (rwBit == RW_WRITE) begin
                  sdaOut <= I2C_NACK;
                  state  <= ST_SUB;
                end else begin
                  // MSB goes out on the same fall that ends the ACK bit.
                  sdaOut  <= iRD_DATA[7];
                  txShift <= {iRD_DATA[6:0], 1'b0};
                  bitCnt  <= 4'd1;
                  state   <= ST_RDATA;
                end
              end
            end
          end

          ST_SUB: begin
            if (sclRise) begin
              shiftReg <= rxByte[6:0];
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd7) begin
                bitCnt   <= '0;
                pointer  <= rxByte;
                ackPhase <= 1'b0;
                state    <= ST_SUB_ACK;
              end
            end
          end

          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (sclFall) begin
              if (!ackPhase) begin
                sdaOut   <= I2C_ACK;
                ackPhase <= 1'b1;
              end else begin
                sdaOut   <= I2C_NACK;
                ackPhase <= 1'b0;
                bitCnt   <= '0;
                state    <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (sclRise) begin
              shiftReg <= rxByte[6:0];
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd7) begin
                bitCnt   <= '0;
                oWR_EN   <= 1'b1;
                oWR_ADDR <= pointer;
                oWR_DATA <= rxByte;
                pointer  <= pointer + 8'd1;
                ackPhase <= 1'b0;
                state    <= ST_WDATA_ACK;
              end
            end
          end

          ST_RDATA: begin
            if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaOut   <= I2C_NACK;
                pointer  <= pointer + 8'd1;
                bitCnt   <= '0;
                ackPhase <= 1'b0;
                state    <= ST_RDATA_ACK;
              end else begin
                sdaOut  <= txShift[7];
                txShift <= {txShift[6:0], 1'b0};
                bitCnt  <= bitCnt + 4'd1;
              end
            end
          end

          ST_RDATA_ACK: begin
            if (sclRise) begin
              if (sdaNow == I2C_ACK) begin
                oRD_REQ  <= 1'b1;
                oRD_ADDR <= pointer;
                ackPhase <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else if (sclFall && ackPhase) begin
              sdaOut   <= iRD_DATA[7];
              txShift  <= {iRD_DATA[6:0], 1'b0};
              bitCnt   <= 4'd1;
              ackPhase <= 1'b0;
              state    <= ST_RDATA;
            end
          end

          default: begin
            // IDLE and IGNORE only leave on START/STOP.
            sdaOut <= I2C_NACK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: table of write frames plus
// hand-written read, partial-byte and reset-during-ACK sequences.
module tb_i2c_slave_responder;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       scl = 1'b1;
  logic       mSda = 1'b1;
  wire        sda;
  logic [7:0] wrAddr, wrData, rdAddr;
  logic [7:0] rdData = '0;
  logic [7:0] rdStage = '0;
  logic       wrEn, rdReq, busy;

  int passCnt = 0;
  int totalCnt = 0;

  int         wrCnt = 0;
  int         rdCnt = 0;
  int         driveCnt = 0;
  logic [7:0] wrALog[256];
  logic [7:0] wrDLog[256];
  logic [7:0] rdALog[256];

  assign sda = mSda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_responder #(
    .SLAVE_ADDR (7'h1A),
    .SYNC_STAGES(2)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rstN),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda),
    .oWR_ADDR (wrAddr),
    .oWR_DATA (wrData),
    .oWR_EN   (wrEn),
    .oRD_ADDR (rdAddr),
    .oRD_REQ  (rdReq),
    .iRD_DATA (rdData),
    .oBUSY    (busy)
  );

  // Register file read model: data = addr ^ A5, valid two cycles after request.
  always @(posedge clk) begin
    if (rdReq) rdStage <= rdAddr ^ 8'hA5;
    rdData <= rdStage;
  end

  // Log strobes and note any cycle where the slave pulls SDA low.
  always @(negedge clk) begin
    if (wrEn) begin
      wrALog[wrCnt[7:0]] <= wrAddr;
      wrDLog[wrCnt[7:0]] <= wrData;
      wrCnt <= wrCnt + 1;
    end
    if (rdReq) begin
      rdALog[rdCnt[7:0]] <= rdAddr;
      rdCnt <= rdCnt + 1;
    end
    if (mSda && sda === 1'b0) driveCnt <= driveCnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic lineLvl();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic waitq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    mSda = 1'b1; waitq(Q);
    scl  = 1'b1; waitq(Q);
    mSda = 1'b0; waitq(Q);
    scl  = 1'b0; waitq(Q);
  endtask

  task automatic i2cStop();
    mSda = 1'b0; waitq(Q);
    scl  = 1'b1; waitq(Q);
    mSda = 1'b1; waitq(Q);
  endtask

  task automatic sendBit(input logic b);
    mSda = b;    waitq(Q);
    scl  = 1'b1; waitq(2 * Q);
    scl  = 1'b0; waitq(Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    mSda = 1'b1; waitq(Q);
    scl  = 1'b1; waitq(Q);
    ack  = lineLvl(); waitq(Q);
    scl  = 1'b0; waitq(Q);
  endtask

  task automatic readByte(input logic mAck, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mSda = 1'b1; waitq(Q);
      scl  = 1'b1; waitq(Q);
      b[i] = lineLvl(); waitq(Q);
      scl  = 1'b0; waitq(Q);
    end
    sendBit(mAck);
    mSda = 1'b1;
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_sda"},    {31'd0, lineLvl()}, 32'd1);
    chk({tag, "_wr_en"},  {31'd0, wrEn},  32'd0);
    chk({tag, "_rd_req"}, {31'd0, rdReq}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy},  32'd0);
    chk({tag, "_wr_addr"}, {24'd0, wrAddr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wrData}, 32'd0);
    chk({tag, "_rd_addr"}, {24'd0, rdAddr}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [39:0] bytes;
    int          n;
    logic        ackLvl;
    int          nWr;
    logic [23:0] wa;
    logic [23:0] wd;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         w0, r0, d0;

    vecs[0] = '{name: "cfg_frame", bytes: {8'h34, 8'h08, 8'hF8, 16'h0000}, n: 3,
                ackLvl: 1'b0, nWr: 1, wa: {8'h08, 16'h0}, wd: {8'hF8, 16'h0}};
    vecs[1] = '{name: "other_addr", bytes: {8'h40, 8'h08, 8'hF8, 16'h0000}, n: 3,
                ackLvl: 1'b1, nWr: 0, wa: 24'h0, wd: 24'h0};
    vecs[2] = '{name: "burst_wrap", bytes: {8'h34, 8'hFE, 8'h11, 8'h22, 8'h33}, n: 5,
                ackLvl: 1'b0, nWr: 3, wa: {8'hFE, 8'hFF, 8'h00}, wd: {8'h11, 8'h22, 8'h33}};

    waitq(4);
    rstN = 1'b1;
    waitq(4);
    chkReset("reset");

    for (int v = 0; v < 3; v++) begin
      w0 = wrCnt;
      d0 = driveCnt;
      i2cStart();
      chk({vecs[v].name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
      for (int i = 0; i < vecs[v].n; i++) begin
        sendByte(vecs[v].bytes[39 - 8 * i -: 8], ack);
        chk({vecs[v].name, "_ack"}, {31'd0, ack}, {31'd0, vecs[v].ackLvl});
      end
      i2cStop();
      waitq(2);
      chk({vecs[v].name, "_busy_after_stop"}, {31'd0, busy}, 32'd0);
      chk({vecs[v].name, "_wr_count"}, wrCnt - w0, vecs[v].nWr);
      for (int k = 0; k < vecs[v].nWr; k++) begin
        chk({vecs[v].name, "_wr_addr"}, {24'd0, wrALog[w0 + k]}, {24'd0, vecs[v].wa[23 - 8 * k -: 8]});
        chk({vecs[v].name, "_wr_data"}, {24'd0, wrDLog[w0 + k]}, {24'd0, vecs[v].wd[23 - 8 * k -: 8]});
      end
      if (vecs[v].ackLvl) chk({vecs[v].name, "_sda_never_driven"}, driveCnt - d0, 0);
    end

    // Write pointer, repeated START, read two bytes (ACK then NACK).
    w0 = wrCnt;
    r0 = rdCnt;
    i2cStart();
    sendByte(8'h34, ack); chk("rd_setup_addr_ack", {31'd0, ack}, 32'd0);
    sendByte(8'h10, ack); chk("rd_setup_sub_ack", {31'd0, ack}, 32'd0);
    i2cStart();
    sendByte(8'h35, ack); chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    chk("rd_req_count_first", rdCnt - r0, 1);
    chk("rd_req_addr_first", {24'd0, rdALog[r0]}, 32'h10);
    readByte(1'b0, rb);
    chk("rd_byte_first", {24'd0, rb}, 32'hB5);
    chk("rd_req_count_second", rdCnt - r0, 2);
    chk("rd_req_addr_second", {24'd0, rdALog[r0 + 1]}, 32'h11);
    readByte(1'b1, rb);
    chk("rd_byte_second", {24'd0, rb}, 32'hB4);
    i2cStop();
    waitq(2);
    chk("rd_req_count_final", rdCnt - r0, 2);
    chk("rd_no_writes", wrCnt - w0, 0);
    chk("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // STOP four bits into a data byte discards it.
    w0 = wrCnt;
    i2cStart();
    sendByte(8'h34, ack); chk("partial_addr_ack", {31'd0, ack}, 32'd0);
    sendByte(8'h20, ack); chk("partial_sub_ack", {31'd0, ack}, 32'd0);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    i2cStop();
    waitq(2);
    chk("partial_no_write", wrCnt - w0, 0);
    chk("partial_busy_after_stop", {31'd0, busy}, 32'd0);
    i2cStart();
    sendByte(8'h34, ack); chk("after_partial_addr_ack", {31'd0, ack}, 32'd0);
    sendByte(8'h20, ack); chk("after_partial_sub_ack", {31'd0, ack}, 32'd0);
    sendByte(8'h5A, ack); chk("after_partial_data_ack", {31'd0, ack}, 32'd0);
    i2cStop();
    waitq(2);
    chk("after_partial_wr_count", wrCnt - w0, 1);
    chk("after_partial_wr_addr", {24'd0, wrALog[w0]}, 32'h20);
    chk("after_partial_wr_data", {24'd0, wrDLog[w0]}, 32'h5A);

    // Reset while the slave holds the address ACK low.
    i2cStart();
    for (int i = 7; i >= 0; i--) sendBit(i == 5 || i == 4 || i == 2);
    mSda = 1'b1;
    waitq(2);
    chk("ack_driven_before_reset", {31'd0, lineLvl()}, 32'd0);
    #1 rstN = 1'b0;
    #1;
    chkReset("mid_ack_reset");
    waitq(2);
    rstN = 1'b1;
    scl = 1'b1;
    waitq(6);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C slave (responder) for the link driven by the board's I2C config master: it decodes the [SLAVE_ADDR, SUB_ADDR, DATA] frames the master emits.
- Samples SCL/SDA oversampled on the system clock and ACKs its own address.
- Turns write frames into register-write strobes; serves single- or multi-byte reads from a register-read port.
- Used as an on-chip codec/decoder register model for bring-up and as a target for the config master in simulation.

Parameters:
- SLAVE_ADDR, 7'h1A, 7-bit device address (8'h34 write byte).
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).

Ports:
- iCLK  in  1  system clock, ≥8× SCL rate (50 MHz nominal).
- iRST_N  in  1  asynchronous active-low reset.
- I2C_SCLK  in  1  I2C clock from master.
- I2C_SDAT  inout  1  open-drain data: drive 0 or Z only.
- oWR_ADDR  out  8  register address of write.
- oWR_DATA  out  8  write data.
- oWR_EN  out  1  one-cycle write strobe.
- oRD_ADDR  out  8  register address of read.
- oRD_REQ  out  1  one-cycle read request.
- iRD_DATA  in  8  read data; valid 2 iCLK after oRD_REQ.
- oBUSY  out  1  high from START to STOP/abort.

Behaviour:
- Reset: I2C_SDAT=Z; oWR_EN=0; oRD_REQ=0; oBUSY=0; oWR_ADDR=oWR_DATA=oRD_ADDR=0; pointer=0; state IDLE.
- Inputs pass through SYNC_STAGES flops plus one history flop. scl_rise/scl_fall/sda_rise/sda_fall are single-cycle events from synchronized values.
- START = sda_fall while SCL high. STOP = sda_rise while SCL high. Both are recognized in every state, including mid-byte.
  - START (or repeated START) → ADDR, bit count cleared, oBUSY=1.
  - STOP → IDLE, oBUSY=0, SDA released.
- Data bits are sampled on scl_rise, MSB first. SDA output changes only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after 8 bits, compare bits[7:1] to SLAVE_ADDR.
  - Mismatch → IGNORE: SDA stays Z until next START/STOP.
  - Match → drive SDA=0 from the next scl_fall through the scl_fall after the ACK bit.
  - If R/W=1: pulse oRD_REQ with oRD_ADDR=pointer in the cycle after the 8th bit is sampled; next state RDATA.
  - Otherwise next state SUB.
- SUB: 8 bits load pointer; ACK; next state WDATA.
- WDATA: on the cycle after the 8th bit is sampled, oWR_ADDR=pointer, oWR_DATA=byte, oWR_EN=1 for one cycle. Then pointer += 1 (8'hFF wraps to 8'h00), ACK, stay in WDATA for burst writes.
- RDATA: the byte is latched from iRD_DATA before the scl_fall that ends the ACK bit.
  - Shift out on each scl_fall: drive 0 for a 0 bit, Z for a 1 bit. Release SDA after the 8th bit.
  - pointer += 1 with wrap.
- RDATA_ACK: sample master bit on scl_rise.
  - ACK (0) → pulse oRD_REQ for the next pointer; return to RDATA.
  - NACK (1) → IGNORE.
- Byte counts continue across SCL stretching; no timeout.
- STOP while a byte is partially received: the partial byte is discarded; no oWR_EN.
- Simultaneous scl and sda change in the same iCLK: treated as a data bit, not START/STOP.
- Reset mid-transfer releases SDA immediately (asynchronous).

Decomposition:
- Shared package i2c_pkg holds:
  - state enum;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - RW_WRITE/RW_READ constants.
- One sub-module, i2c_line_sync, does synchronization plus edge and START/STOP detection for SCL/SDA. The FSM, shifter and pointer stay in the top module.

Test Plan:
- Config-master frame {8'h34, 8'h08, 8'hF8} then STOP → ACK on all three bytes; one oWR_EN with oWR_ADDR=8'h08, oWR_DATA=8'hF8; oBUSY low after STOP.
- Address 8'h40 write → SDA never driven; no oWR_EN; IGNORE until next START.
- Burst {8'h34, 8'hFE, 8'h11, 8'h22, 8'h33} → writes (FE,11), (FF,22), (00,33), showing pointer wrap.
- Write {8'h34, 8'h10}, repeated START, 8'h35, read 2 bytes with ACK then NACK, bench iRD_DATA = addr^8'hA5 →
  - oRD_REQ at 8'h10 and 8'h11;
  - SDA carries 8'hB5 then 8'hB4.
- STOP after 4 bits of a data byte → no oWR_EN; next frame {34, 20, 5A} → write (20, 5A).
- iRST_N asserted while slave drives ACK low → SDA Z within the same cycle; all outputs at reset values.
